// File: rtl/sine_duty_seq_if.sv
// Duty-word handshake and sequencing controls between sine_duty_seq and its PWM stage.
// The sequencer drives the duty word; the PWM side supplies ticks, settings and ready.
interface sine_duty_seq_if #(
  parameter int R  = 6,
  parameter int DW = 16
);
  logic          en;
  logic          period_tick;
  logic [DW-1:0] step_div;
  logic [5:0]    phase_inc;
  logic          duty_ready;
  logic [R-1:0]  duty;
  logic          duty_valid;
  logic [5:0]    phase;
  logic          overrun;

  modport master (
    input  en, period_tick, step_div, phase_inc, duty_ready,
    output duty, duty_valid, phase, overrun
  );

  modport slave (
    output en, period_tick, step_div, phase_inc, duty_ready,
    input  duty, duty_valid, phase, overrun
  );
endinterface

// File: rtl/sine_duty_seq.sv
// 64-point sine duty sequencer: steps phase every step_div PWM periods, folds it
// through a quarter-wave LUT and presents each duty word on a valid/ready handshake.
//
// state   | meaning
// IDLE    | disabled, counter held at 0, no word presented
// COUNT   | counting period ticks toward the next sample
// PRESENT | duty word valid and waiting for acceptance; ticks keep counting
module sine_duty_seq #(
  parameter int R  = 6,
  parameter int DW = 16
) (
  input logic             clk,
  input logic             rst_n,
  sine_duty_seq_if.master bus
);

  typedef enum logic [1:0] {IDLE, COUNT, PRESENT} state_t;

  // sin(pi*i/32) scaled by 2^30; exact for i = 0 and 16
  localparam longint unsigned SIN_Q30 [17] = '{
    64'd0,          64'd105245103,  64'd209476638,  64'd311690799,
    64'd410903207,  64'd506158392,  64'd596538995,  64'd681174602,
    64'd759250125,  64'd830013654,  64'd892783698,  64'd946955747,
    64'd992008094,  64'd1027506862, 64'd1053110176, 64'd1068571463,
    64'd1073741824
  };
  localparam longint unsigned AMP = (64'd1 << (R - 1)) - 64'd1;

  logic [R-2:0] lut [17];

  for (genvar gi = 0; gi < 17; gi++) begin : g_lut
    localparam longint unsigned PROD = AMP * SIN_Q30[gi];
    localparam longint unsigned MAG  = (PROD + 64'd536870912) >> 30;
    assign lut[gi] = MAG[R-2:0];
  end

  state_t        state, state_nxt;
  logic [DW-1:0] cnt, cnt_nxt;
  logic [5:0]    phase_q, phase_nxt;
  logic [R-1:0]  duty_q, duty_nxt;
  logic          valid_q, valid_nxt;
  logic          ovr_q, ovr_nxt;

  logic [DW:0]   cnt_inc, thr;
  logic          step_done;
  logic [5:0]    phase_step;
  logic [4:0]    fold_m, fold_idx;
  logic [R-2:0]  mag;
  logic [R-1:0]  duty_step;

  assign cnt_inc    = {1'b0, cnt} + {{DW{1'b0}}, 1'b1};
  assign thr        = (bus.step_div == '0) ? {{DW{1'b0}}, 1'b1} : {1'b0, bus.step_div};
  assign step_done  = bus.period_tick && (cnt_inc >= thr);
  assign phase_step = phase_q + bus.phase_inc;

  assign fold_m    = phase_step[4:0];
  assign fold_idx  = (fold_m > 5'd16) ? 5'(6'd32 - {1'b0, fold_m}) : fold_m;
  assign mag       = lut[fold_idx];
  // Upper half: mid + T; lower half: (mid - 1) - T, which is the bitwise inverse of T
  assign duty_step = phase_step[5] ? {1'b0, ~mag} : {1'b1, mag};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      phase_q <= '0;
      duty_q  <= {1'b1, {(R-1){1'b0}}};
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      phase_q <= phase_nxt;
      duty_q  <= duty_nxt;
      valid_q <= valid_nxt;
      ovr_q   <= ovr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    phase_nxt = phase_q;
    duty_nxt  = duty_q;
    valid_nxt = valid_q;
    ovr_nxt   = ovr_q;
    if (!bus.en) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
      valid_nxt = 1'b0;
      ovr_nxt   = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state_nxt = COUNT;
          cnt_nxt   = '0;
        end
        COUNT, PRESENT: begin
          if (bus.period_tick) cnt_nxt = cnt_inc[DW-1:0];
          if (step_done) begin
            cnt_nxt   = '0;
            phase_nxt = phase_step;
            duty_nxt  = duty_step;
            valid_nxt = 1'b1;
            state_nxt = PRESENT;
            // Simultaneous acceptance retires the old word cleanly
            if (state == PRESENT && !bus.duty_ready) ovr_nxt = 1'b1;
          end else if (state == PRESENT && bus.duty_ready) begin
            valid_nxt = 1'b0;
            state_nxt = COUNT;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign bus.duty       = duty_q;
  assign bus.duty_valid = valid_q;
  assign bus.phase      = phase_q;
  assign bus.overrun    = ovr_q;

endmodule

// File: tb/tb_sine_duty_seq.sv
// Self-checking bench for sine_duty_seq: directed scenarios plus randomized traffic
// compared against a real-arithmetic sine reference model.
module tb_sine_duty_seq;
  localparam int R  = 6;
  localparam int DW = 16;
  localparam real PI = 3.14159265358979;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  sine_duty_seq_if #(.R(R), .DW(DW)) bus ();
  sine_duty_seq #(.R(R), .DW(DW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model state
  bit m_run, m_valid, m_ovr;
  int m_cnt, m_phase, m_duty;

  function automatic int ref_duty(int k);
    int  i;
    int  t;
    real a;
    i = k % 32;
    if (i > 16) i = 32 - i;
    a = 2.0 ** (R - 1) - 1.0;
    t = $rtoi($floor(a * $sin(PI * i / 32.0) + 0.5));
    return (k < 32) ? (2 ** (R - 1) + t) : (2 ** (R - 1) - 1 - t);
  endfunction

  task automatic model_reset();
    m_run = 0; m_valid = 0; m_ovr = 0;
    m_cnt = 0; m_phase = 0; m_duty = 2 ** (R - 1);
  endtask

  task automatic model_step();
    int  thr;
    bit  done;
    if (!rst_n) begin
      model_reset();
    end else if (!bus.en) begin
      m_run = 0; m_cnt = 0; m_valid = 0; m_ovr = 0;
    end else if (!m_run) begin
      m_run = 1;
    end else begin
      thr  = (bus.step_div == 0) ? 1 : int'(bus.step_div);
      done = bus.period_tick && (m_cnt + 1 >= thr);
      if (done) begin
        if (m_valid && !bus.duty_ready) m_ovr = 1;
        m_cnt   = 0;
        m_phase = (m_phase + int'(bus.phase_inc)) % 64;
        m_duty  = ref_duty(m_phase);
        m_valid = 1;
      end else begin
        if (bus.period_tick) m_cnt++;
        if (m_valid && bus.duty_ready) m_valid = 0;
      end
    end
  endtask

  // One clock: model samples the same inputs as the DUT edge, outputs checked at negedge
  task automatic cyc(input bit tick);
    bus.period_tick = tick;
    @(posedge clk);
    model_step();
    @(negedge clk);
    bus.period_tick = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.en = 1'b0; bus.period_tick = 1'b0; bus.duty_ready = 1'b0;
    bus.step_div = '0; bus.phase_inc = '0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (bus.duty !== R'(32)) begin bad++; $display("FAIL reset_duty got=%0d exp=32", bus.duty); end
    total++; if (bus.duty_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b exp=0", bus.duty_valid); end
    total++; if (bus.phase !== 6'd0) begin bad++; $display("FAIL reset_phase got=%0d exp=0", bus.phase); end
    total++; if (bus.overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun got=%0b exp=0", bus.overrun); end
    bus.step_div = 16'd1; bus.phase_inc = 6'd5; bus.duty_ready = 1'b1;
    for (int i = 0; i < 20; i++) cyc(1'b1);
    total++; if (bus.duty_valid !== 1'b0 || bus.phase !== 6'd0 || bus.duty !== R'(32))
      begin bad++; $display("FAIL idle_ticks got valid=%0b phase=%0d duty=%0d exp 0/0/32", bus.duty_valid, bus.phase, bus.duty); end
  endtask

  task automatic test_basic_step();
    int exp_duty [2] = '{35, 38};
    do_reset();
    bus.step_div = 16'd3; bus.phase_inc = 6'd1; bus.duty_ready = 1'b1; bus.en = 1'b1;
    cyc(1'b0);
    for (int n = 1; n <= 6; n++) begin
      for (int j = 0; j < 9; j++) cyc(1'b0);
      cyc(1'b1);
      if (n % 3 == 0) begin
        total++; if (bus.duty_valid !== 1'b1) begin bad++; $display("FAIL basic_valid tick=%0d got=%0b exp=1", n, bus.duty_valid); end
        total++; if (bus.duty !== R'(exp_duty[n/3-1])) begin bad++; $display("FAIL basic_duty tick=%0d got=%0d exp=%0d", n, bus.duty, exp_duty[n/3-1]); end
        total++; if (bus.phase !== 6'(n/3)) begin bad++; $display("FAIL basic_phase tick=%0d got=%0d exp=%0d", n, bus.phase, n/3); end
      end else begin
        total++; if (bus.duty_valid !== 1'b0) begin bad++; $display("FAIL basic_novalid tick=%0d got=%0b exp=0", n, bus.duty_valid); end
      end
      cyc(1'b0);
      total++; if (bus.duty_valid !== 1'b0) begin bad++; $display("FAIL basic_onecycle tick=%0d got=%0b exp=0", n, bus.duty_valid); end
    end
    total++; if (bus.overrun !== 1'b0) begin bad++; $display("FAIL basic_overrun got=%0b exp=0", bus.overrun); end
  endtask

  task automatic test_wrap();
    int ed [4] = '{63, 31, 0, 32};
    int ep [4] = '{16, 32, 48, 0};
    do_reset();
    bus.step_div = 16'd1; bus.phase_inc = 6'd16; bus.duty_ready = 1'b1; bus.en = 1'b1;
    cyc(1'b0);
    for (int n = 0; n < 4; n++) begin
      cyc(1'b1);
      total++; if (bus.duty !== R'(ed[n]) || bus.phase !== 6'(ep[n]) || bus.duty_valid !== 1'b1)
        begin bad++; $display("FAIL wrap_%0d got duty=%0d phase=%0d valid=%0b exp %0d/%0d/1", n, bus.duty, bus.phase, bus.duty_valid, ed[n], ep[n]); end
      cyc(1'b0);
    end
  endtask

  task automatic test_overrun();
    do_reset();
    bus.step_div = 16'd1; bus.phase_inc = 6'd1; bus.duty_ready = 1'b0; bus.en = 1'b1;
    cyc(1'b0);
    cyc(1'b1);
    total++; if (bus.duty !== R'(35) || bus.duty_valid !== 1'b1 || bus.overrun !== 1'b0)
      begin bad++; $display("FAIL ovr_first got duty=%0d valid=%0b ovr=%0b exp 35/1/0", bus.duty, bus.duty_valid, bus.overrun); end
    cyc(1'b1);
    total++; if (bus.duty !== R'(38) || bus.overrun !== 1'b1)
      begin bad++; $display("FAIL ovr_second got duty=%0d ovr=%0b exp 38/1", bus.duty, bus.overrun); end
    bus.duty_ready = 1'b1;
    cyc(1'b0);
    total++; if (bus.duty_valid !== 1'b0 || bus.overrun !== 1'b1)
      begin bad++; $display("FAIL ovr_accept got valid=%0b ovr=%0b exp 0/1", bus.duty_valid, bus.overrun); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    bus.step_div = 16'd2; bus.phase_inc = 6'd1; bus.duty_ready = 1'b0; bus.en = 1'b1;
    cyc(1'b0);
    cyc(1'b1);
    cyc(1'b1);
    total++; if (bus.duty !== R'(35) || bus.duty_valid !== 1'b1)
      begin bad++; $display("FAIL b2b_first got duty=%0d valid=%0b exp 35/1", bus.duty, bus.duty_valid); end
    cyc(1'b1);
    total++; if (bus.duty_valid !== 1'b1) begin bad++; $display("FAIL b2b_hold got=%0b exp=1", bus.duty_valid); end
    bus.duty_ready = 1'b1;
    cyc(1'b1);
    bus.duty_ready = 1'b0;
    total++; if (bus.duty !== R'(38) || bus.duty_valid !== 1'b1 || bus.overrun !== 1'b0)
      begin bad++; $display("FAIL b2b_same got duty=%0d valid=%0b ovr=%0b exp 38/1/0", bus.duty, bus.duty_valid, bus.overrun); end
  endtask

  task automatic test_en_drop();
    bus.en = 1'b0;
    cyc(1'b0);
    total++; if (bus.duty_valid !== 1'b0 || bus.phase !== 6'd2 || bus.duty !== R'(38) || bus.overrun !== 1'b0)
      begin bad++; $display("FAIL endrop got valid=%0b phase=%0d duty=%0d ovr=%0b exp 0/2/38/0", bus.duty_valid, bus.phase, bus.duty, bus.overrun); end
    bus.en = 1'b1; bus.step_div = 16'd1; bus.duty_ready = 1'b0;
    cyc(1'b0);
    cyc(1'b1);
    cyc(1'b1);
    total++; if (bus.duty_valid !== 1'b1 || bus.phase !== 6'd4 || bus.overrun !== 1'b1)
      begin bad++; $display("FAIL pre_rst got valid=%0b phase=%0d ovr=%0b exp 1/4/1", bus.duty_valid, bus.phase, bus.overrun); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (bus.duty !== R'(32) || bus.duty_valid !== 1'b0 || bus.phase !== 6'd0 || bus.overrun !== 1'b0)
      begin bad++; $display("FAIL async_rst got duty=%0d valid=%0b phase=%0d ovr=%0b exp 32/0/0/0", bus.duty, bus.duty_valid, bus.phase, bus.overrun); end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    do_reset();
    bus.en = 1'b1;
    for (int c = 0; c < 2000; c++) begin
      if (c % 40 == 0) begin
        bus.step_div  = 16'($urandom_range(0, 4));
        bus.phase_inc = 6'($urandom_range(0, 63));
      end
      bus.en         = ($urandom_range(0, 99) < 97);
      bus.duty_ready = $urandom_range(0, 1) == 1;
      cyc($urandom_range(0, 2) == 0);
      total++; if (bus.duty !== R'(m_duty)) begin bad++; $display("FAIL rand_duty cyc=%0d got=%0d exp=%0d", c, bus.duty, m_duty); end
      total++; if (bus.duty_valid !== m_valid) begin bad++; $display("FAIL rand_valid cyc=%0d got=%0b exp=%0b", c, bus.duty_valid, m_valid); end
      total++; if (bus.phase !== 6'(m_phase)) begin bad++; $display("FAIL rand_phase cyc=%0d got=%0d exp=%0d", c, bus.phase, m_phase); end
      total++; if (bus.overrun !== m_ovr) begin bad++; $display("FAIL rand_overrun cyc=%0d got=%0b exp=%0b", c, bus.overrun, m_ovr); end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.en = 1'b0; bus.period_tick = 1'b0; bus.duty_ready = 1'b0;
    bus.step_div = '0; bus.phase_inc = '0;
    @(negedge clk);
    test_reset();
    test_basic_step();
    test_wrap();
    test_overrun();
    test_back_to_back();
    test_en_drop();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sine_duty_seq.md
# sine_duty_seq

Upstream duty-cycle sequencer for the `pwm_basico` PWM stage. It steps a 64-point sine phase at a rate set in PWM periods, folds it through a quarter-wave LUT, and presents each new duty word on a valid/ready handshake. The PWM stage accepts the word at its period wrap. All sine sequencing lives here; the PWM stage stays a pure compare engine.

## Interface
- `R`, default 6: duty width, legal range 4..12. LUT magnitudes T(i) = round_half_up((2^(R-1)-1)·sin(π·i/32)) for i = 0..16, computed at elaboration.
- `DW`, default 16: width of `step_div` and of the internal tick counter.
- `clk` in 1: the single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `en` in 1: run enable.
- `period_tick` in 1: one-cycle pulse from the PWM stage when its counter wraps.
- `step_div` in DW: PWM periods per sample. 0 is treated as 1.
- `phase_inc` in 6: phase increment per sample, mod 64.
- `duty_ready` in 1: PWM stage accepts the presented duty.
- `duty` out R: registered duty word.
- `duty_valid` out 1: `duty` holds an unaccepted sample.
- `phase` out 6: current sample index k.
- `overrun` out 1: sticky flag; a sample was overwritten before it was accepted.

## Operation
- Reset values: `duty` = 2^(R-1), `duty_valid` = 0, `phase` = 0, `overrun` = 0, tick counter = 0, state IDLE.
- Duty function, with m = k mod 32 and idx = m if m ≤ 16, else 32−m:
  - k < 32: duty = 2^(R-1) + T(idx).
  - k ≥ 32: duty = 2^(R-1) − 1 − T(idx).
  - For R = 6: k=0 → 32, k=16 → 63, k=32 → 31, k=48 → 0.
- States:
  - IDLE: counter held at 0, `duty_valid` = 0. `en`=1 → COUNT.
  - COUNT: each `period_tick` increments the counter.
  - Step completion: a tick with counter+1 ≥ max(`step_div`,1).
    - Counter ← 0, `phase` ← `phase` + `phase_inc` (6-bit wrap).
    - `duty` ← f(new phase), `duty_valid` ← 1, go to PRESENT.
  - PRESENT: `duty_valid` = 1 and `duty` is stable. Ticks keep counting.
    - `duty_valid` & `duty_ready`, no completion: `duty_valid` ← 0, go to COUNT.
    - Completion without acceptance: the new sample overwrites `duty` and `phase`, `duty_valid` stays 1, `overrun` ← 1.
    - Acceptance and completion in the same cycle: the old word counts as accepted, the new word is presented, `duty_valid` stays 1, `overrun` unchanged.
- `step_div` is compared live, with no latching. Lowering it below the current count completes the step on the next tick (≥ comparison).
- `phase_inc` = 0 is legal: the same duty word is re-presented every step.
- `en` falling, in any state:
  - Next edge: `duty_valid` ← 0, counter ← 0, go to IDLE, `overrun` ← 0.
  - `duty` and `phase` are retained. Any pending word is discarded.
- `duty_ready` is ignored while `duty_valid` = 0.
- `period_tick` is ignored in IDLE.

## Timing
- Completing tick sampled at edge N: `duty`, `phase` and `duty_valid` are updated at edge N. They are visible during cycle N+1. The LUT plus adder path is combinational into registers.
- Handshake completes on the edge where `duty_valid` & `duty_ready`. `duty_valid` is low the following cycle unless a completion occurred at that same edge.
- Minimum sample spacing: one `period_tick` (`step_div` ≤ 1).
- `rst_n` assertion takes effect immediately, without a clock, including mid-PRESENT. Deassertion is synchronized externally.
- `en` rising: IDLE→COUNT at the next edge. The first tick counted is the one sampled in COUNT.

## Test plan
- Reset with `duty_ready`=0, then release → `duty`=32, `duty_valid`=0, `phase`=0, `overrun`=0. Outputs stay there with `en`=0 while ticks run.
- `en`=1, `step_div`=3, `phase_inc`=1, `duty_ready` tied 1, tick every 10 clk → one-cycle valid after the 3rd tick with `duty`=35, `phase`=1. After the 6th tick, `duty`=38, `phase`=2. `overrun` stays 0.
- `phase_inc`=16, `step_div`=1, ready tied 1 → successive duty 63, 31, 0, 32 with phase 16, 32, 48, 0 (wrap).
- `duty_ready`=0, `step_div`=1, `phase_inc`=1 from phase 0:
  - Tick 1 → `duty`=35, valid.
  - Tick 2 → `duty`=38, `overrun`=1.
  - Raise ready → `duty_valid` drops next cycle; `overrun` stays 1.
- `duty_ready` pulsed on exactly the cycle a completing tick arrives → new `duty` presented, `duty_valid` continuously 1, `overrun`=0.
- Drop `en` while in PRESENT → `duty_valid`=0 next cycle, `phase` retained. Later, assert `rst_n`=0 mid-PRESENT without a clock edge → all outputs at reset values immediately.
